// File: rtl/phy_tx_lane.sv
// Lane serializer: 32-bit words out MSB first in 32-cycle slots; COM sync after reset, then IDL/DATA.
// Optional macro SKIP_INSERT_EN forces a COM slot after every SKIP_INTERVAL RUN slots.
module phy_tx_lane #(
  parameter int         COM_WORDS     = 4,
  parameter logic [7:0] COM_SYM       = 8'hBC,
  parameter logic [7:0] IDL_SYM       = 8'h7C,
  parameter int         SKIP_INTERVAL = 8
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        serial_out,
  output logic        active,
  output logic        slot_start
);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic        started_q, started_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  com_cnt_q, com_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        slot_start_q, slot_start_d;
  logic        boundary, accept, send_data, send_com;
  logic [31:0] slot_word;
`ifdef SKIP_INSERT_EN
  logic [7:0]  slot_cnt_q, slot_cnt_d;
  logic        skip_q, skip_d;
`endif

  // started_q low means the next edge opens slot 0 after reset release
  assign boundary   = !started_q || (byte_cnt_q == 2'd3 && bit_cnt_q == 3'd7);
  assign ready_out  = !buf_full_q && !reset;
  assign accept     = valid_in && ready_out;
  assign serial_out = serial_q;
  assign active     = active_q;
  assign slot_start = slot_start_q;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      started_q    <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      com_cnt_q    <= 8'd0;
      shift_q      <= 32'd0;
      buf_q        <= 32'd0;
      buf_full_q   <= 1'b0;
      serial_q     <= 1'b0;
      active_q     <= 1'b0;
      slot_start_q <= 1'b0;
`ifdef SKIP_INSERT_EN
      slot_cnt_q   <= 8'd0;
      skip_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      com_cnt_q    <= com_cnt_d;
      shift_q      <= shift_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      serial_q     <= serial_d;
      active_q     <= active_d;
      slot_start_q <= slot_start_d;
`ifdef SKIP_INSERT_EN
      slot_cnt_q   <= slot_cnt_d;
      skip_q       <= skip_d;
`endif
    end
  end

  // Slot-type decision, taken only at slot boundaries
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    send_com  = 1'b0;
    send_data = 1'b0;
`ifdef SKIP_INSERT_EN
    slot_cnt_d = slot_cnt_q;
    skip_d     = skip_q;
`endif
    if (boundary) begin
      if (state_q == ST_SYNC) begin
        if (started_q && com_cnt_q == 8'(COM_WORDS - 1)) begin
          state_d   = ST_RUN;
          send_data = buf_full_q;
`ifdef SKIP_INSERT_EN
          slot_cnt_d = 8'd0;
          skip_d     = 1'b0;
`endif
        end else begin
          send_com = 1'b1;
          if (started_q) begin
            com_cnt_d = com_cnt_q + 8'd1;
          end
        end
      end else begin
`ifdef SKIP_INSERT_EN
        if (skip_q) begin
          slot_cnt_d = 8'd0;
          skip_d     = 1'b0;
        end else if (slot_cnt_q + 8'd1 == 8'(SKIP_INTERVAL)) begin
          skip_d   = 1'b1;
          send_com = 1'b1;
        end else begin
          slot_cnt_d = slot_cnt_q + 8'd1;
        end
        send_data = buf_full_q && !send_com;
`else
        send_data = buf_full_q;
`endif
      end
    end
  end

  // Datapath: holding buffer, shift register and serial output
  always_comb begin
    slot_word  = send_data ? buf_q : (send_com ? {4{COM_SYM}} : {4{IDL_SYM}});
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (send_data) begin
      buf_full_d = 1'b0;
    end
    if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end
    if (boundary) begin
      shift_d    = {slot_word[30:0], 1'b0};
      serial_d   = slot_word[31];
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
    end else begin
      shift_d    = {shift_q[30:0], 1'b0};
      serial_d   = shift_q[31];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_cnt_d = (bit_cnt_q == 3'd7) ? byte_cnt_q + 2'd1 : byte_cnt_q;
    end
    slot_start_d = boundary;
    started_d    = 1'b1;
    active_d     = active_q || (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_phy_tx_lane.sv
// Bench for phy_tx_lane: cycle-indexed slot model (slot n = t/32) compared bit by bit.
module tb_phy_tx_lane;
  localparam int COM_WORDS = 4;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        valid_in = 1'b0;
  logic        ready_out, serial_out, active, slot_start;

  int total = 0;
  int bad = 0;

  // Model: t = cycles since reset release (-1 in reset)
  int          t = -1;
  logic        m_full = 1'b0;
  logic [31:0] m_buf = 32'd0;
  logic [31:0] m_slot = 32'd0;
  logic        m_is_data = 1'b0;
  logic [31:0] pend[$];
  logic        rand_mode = 1'b0;

  phy_tx_lane dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .serial_out(serial_out),
    .active    (active),
    .slot_start(slot_start)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic tick();
    logic acc, from_pend, e_ser, e_act, e_ss;
    from_pend = 1'b0;
    if (pend.size() > 0) begin
      valid_in  = 1'b1;
      data_in   = pend[0];
      from_pend = 1'b1;
    end else if (rand_mode) begin
      valid_in = ($urandom_range(0, 3) == 0);
      data_in  = $urandom;
    end else begin
      valid_in = 1'b0;
    end
    #1;
    if (reset) check_val("ready_rst", ready_out, 0);
    else       check_val("ready", ready_out, !m_full);
    acc = !reset && valid_in && !m_full;
    if (reset) begin
      t = -1; m_full = 1'b0; m_is_data = 1'b0;
      e_ser = 1'b0; e_act = 1'b0; e_ss = 1'b0;
    end else begin
      t++;
      if (t % 32 == 0) begin
        m_is_data = 1'b0;
        if (t / 32 < COM_WORDS) m_slot = {4{8'hBC}};
        else if (m_full) begin
          m_slot = m_buf; m_full = 1'b0; m_is_data = 1'b1;
        end else m_slot = {4{8'h7C}};
      end
      if (acc) begin
        m_buf = data_in; m_full = 1'b1;
      end
      e_ser = m_slot[31 - (t % 32)];
      e_act = (t >= 32 * COM_WORDS);
      e_ss  = (t % 32 == 0);
    end
    @(posedge clk_32f);
    #1;
    if (acc && from_pend) void'(pend.pop_front());
    check_val("serial", serial_out, e_ser);
    check_val("active", active, e_act);
    check_val("slot_start", slot_start, e_ss);
  endtask

  task automatic wait_pos(input int pos, input bit need_data, input bit need_empty);
    int k = 0;
    while (!(t >= 0 && t % 32 == pos && (!need_data || m_is_data) && (!need_empty || !m_full))
           && k < 300) begin
      tick();
      k++;
    end
    check_val("wait_bound", (k < 300), 1);
  endtask

  initial begin
    @(negedge clk_32f);
    repeat (3) tick();
    reset = 1'b0;
    // sync phase and first IDL slots
    repeat (160) tick();
    // single word mid-IDLE slot
    wait_pos(10, 1'b0, 1'b1);
    pend.push_back(32'hDEADBEEF);
    repeat (100) tick();
    // back-to-back words
    pend.push_back(32'h01234567);
    pend.push_back(32'h89ABCDEF);
    repeat (130) tick();
    // word presented exactly on a boundary edge with empty buffer
    wait_pos(31, 1'b0, 1'b1);
    pend.push_back(32'hA5A5A5A5);
    repeat (80) tick();
    // reset at byte 2 bit 4 of a DATA slot with a second word buffered
    pend.push_back(32'h13579BDF);
    pend.push_back(32'h2468ACE0);
    wait_pos(19, 1'b1, 1'b0);
    reset = 1'b1;
    pend.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (170) tick();
    // random traffic with occasional resets
    rand_mode = 1'b1;
    repeat (3000) begin
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    rand_mode = 1'b0;
    repeat (40) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "timeout");
  end
endmodule
